// File: rtl/cphy_demapper.sv
// C-PHY symbol-to-word demapper: gathers 7 serial symbols into a word, decodes
// the flip pattern into a 16-bit value, and presents it on a ready/valid output.
module cphy_demapper #(
  parameter bit CHECK_FLIPPED_ZERO = 1'b1
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        RxSymValid,
  input  logic        RxSymFlip,
  input  logic        RxSymRotation,
  input  logic        RxSymPolarity,
  input  logic        RxSync,
  input  logic        RxDataReady,
  output logic [15:0] RxData,
  output logic        RxDataValid,
  output logic        RxCodeErr,
  output logic        RxOverflow,
  output logic        RxAligned
);

  localparam logic [0:0] ST_UNALIGNED = 1'b0;
  localparam logic [0:0] ST_COLLECT   = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  flips_q, flips_d;
  logic [13:0] pairs_q, pairs_d;
  logic        word_done_q, word_done_d;
  logic [6:0]  word_flips_q, word_flips_d;
  logic [13:0] word_pairs_q, word_pairs_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [16:0] decoded_s;

  // Returns {code_err, data}; pair k lives in pairs[2k+1:2k] as {rotation, polarity}.
  function automatic logic [16:0] decode_word(input logic [6:0] flips,
                                              input logic [13:0] pairs);
    logic [13:0] packed_v;
    logic [2:0]  nflip_v;
    logic [2:0]  pos_v;
    logic [4:0]  n_v;
    logic [4:0]  idx_v;
    logic        bad_v;
    logic [15:0] data_v;
    int          w;
    packed_v = 14'h0000;
    nflip_v  = 3'd0;
    pos_v    = 3'd0;
    n_v      = 5'd0;
    idx_v    = 5'd0;
    bad_v    = 1'b0;
    data_v   = 16'h0000;
    w        = 0;
    for (int k = 0; k < 7; k++) begin
      if (flips[k]) begin
        nflip_v = nflip_v + 3'd1;
        pos_v   = k[2:0];
        if (CHECK_FLIPPED_ZERO && (pairs[2*k +: 2] != 2'b00)) begin
          bad_v = 1'b1;
        end else begin
          bad_v = bad_v;
        end
      end else begin
        packed_v[2*w +: 2] = pairs[2*k +: 2];
        w = w + 1;
      end
    end
    // Lexicographic index of the flipped pair (i,j); only meaningful for two flips.
    for (int a = 0; a < 6; a++) begin
      for (int b = a + 1; b < 7; b++) begin
        if (flips[a] && flips[b]) begin
          n_v = idx_v;
        end else begin
          n_v = n_v;
        end
        idx_v = idx_v + 5'd1;
      end
    end
    case (nflip_v)
      3'd0: data_v = {2'b00, pairs};
      3'd1: data_v = {4'd4 + {1'b0, pos_v}, packed_v[11:0]};
      3'd2: begin
        if (flips == 7'h60) begin
          bad_v = 1'b1;
        end else begin
          data_v = {6'h2C + {1'b0, n_v}, packed_v[9:0]};
        end
      end
      default: bad_v = 1'b1;
    endcase
    if (bad_v) begin
      data_v = 16'h0000;
    end else begin
      data_v = data_v;
    end
    return {bad_v, data_v};
  endfunction

  assign decoded_s = decode_word(word_flips_q, word_pairs_q);

  // Symbol collection and word alignment.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flips_d      = flips_q;
    pairs_d      = pairs_q;
    word_done_d  = 1'b0;
    word_flips_d = word_flips_q;
    word_pairs_d = word_pairs_q;
    if (RxSymValid) begin
      if (RxSync) begin
        state_d = ST_COLLECT;
        flips_d = {6'b000000, RxSymFlip};
        pairs_d = {12'h000, RxSymRotation, RxSymPolarity};
        cnt_d   = 3'd1;
      end else if (state_q == ST_COLLECT) begin
        flips_d[cnt_q]               = RxSymFlip;
        pairs_d[{cnt_q, 1'b0} +: 2]  = {RxSymRotation, RxSymPolarity};
        if (cnt_q == 3'd6) begin
          word_done_d  = 1'b1;
          word_flips_d = flips_d;
          word_pairs_d = pairs_d;
          cnt_d        = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else begin
        state_d = ST_UNALIGNED;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output register with ready/valid handshake; a word arriving into a stalled
  // output is dropped so the held word stays stable.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovf_d   = 1'b0;
    if (valid_q && RxDataReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (word_done_q) begin
      if (valid_q && !RxDataReady) begin
        ovf_d = 1'b1;
      end else begin
        data_d  = decoded_s[15:0];
        err_d   = decoded_s[16];
        valid_d = 1'b1;
      end
    end else begin
      ovf_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q      <= ST_UNALIGNED;
      cnt_q        <= 3'd0;
      flips_q      <= 7'h00;
      pairs_q      <= 14'h0000;
      word_done_q  <= 1'b0;
      word_flips_q <= 7'h00;
      word_pairs_q <= 14'h0000;
      data_q       <= 16'h0000;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flips_q      <= flips_d;
      pairs_q      <= pairs_d;
      word_done_q  <= word_done_d;
      word_flips_q <= word_flips_d;
      word_pairs_q <= word_pairs_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign RxData      = data_q;
  assign RxDataValid = valid_q;
  assign RxCodeErr   = err_q;
  assign RxOverflow  = ovf_q;
  assign RxAligned   = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_cphy_demapper.sv
// Self-checking bench for cphy_demapper: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_cphy_demapper;
  localparam bit CFZ = 1'b1;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        RxSymValid, RxSymFlip, RxSymRotation, RxSymPolarity, RxSync, RxDataReady;
  logic [15:0] RxData;
  logic        RxDataValid, RxCodeErr, RxOverflow, RxAligned;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  cphy_demapper #(.CHECK_FLIPPED_ZERO(CFZ)) dut (
    .Clk(Clk), .RstN(RstN), .RxSymValid(RxSymValid), .RxSymFlip(RxSymFlip),
    .RxSymRotation(RxSymRotation), .RxSymPolarity(RxSymPolarity), .RxSync(RxSync),
    .RxDataReady(RxDataReady), .RxData(RxData), .RxDataValid(RxDataValid),
    .RxCodeErr(RxCodeErr), .RxOverflow(RxOverflow), .RxAligned(RxAligned)
  );

  // Reference model state
  bit        m_aligned;
  int        m_k;
  bit [6:0]  m_f;
  bit [13:0] m_p;
  bit        m_pend;
  bit [6:0]  m_wf;
  bit [13:0] m_wp;
  bit [15:0] m_data;
  bit        m_valid, m_err, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit [16:0] ref_decode(input bit [6:0] f, input bit [13:0] pr);
    int pos[$];
    int payload = 0;
    int w = 0;
    int n;
    int data = 0;
    bit err = 0;
    for (int k = 0; k < 7; k++) begin
      if (f[k]) begin
        pos.push_back(k);
        if (CFZ && pr[2*k +: 2] != 2'b00) err = 1;
      end else begin
        payload += int'(pr[2*k +: 2]) << (2 * w);
        w++;
      end
    end
    if (pos.size() >= 3) err = 1;
    if (pos.size() == 2 && pos[0] == 5) err = 1;
    if (err) return {1'b1, 16'h0000};
    if (pos.size() == 0) data = payload;
    else if (pos.size() == 1) data = (4 + pos[0]) * 4096 + payload;
    else begin
      n = pos[0] * (13 - pos[0]) / 2 + (pos[1] - pos[0] - 1);
      data = (44 + n) * 1024 + payload;
    end
    return {1'b0, 16'(data)};
  endfunction

  function automatic bit [13:0] spread(input bit [6:0] f, input bit [13:0] payload);
    bit [13:0] pr = 14'h0000;
    int w = 0;
    for (int k = 0; k < 7; k++) begin
      if (!f[k]) begin
        pr[2*k +: 2] = payload[2*w +: 2];
        w++;
      end
    end
    return pr;
  endfunction

  task automatic model_reset();
    m_aligned = 0; m_k = 0; m_f = 0; m_p = 0; m_pend = 0;
    m_data = 0; m_valid = 0; m_err = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit v, input bit f, input bit r, input bit p,
                            input bit s, input bit rdy);
    bit old_valid = m_valid;
    bit [16:0] dec;
    if (m_valid && rdy) m_valid = 0;
    m_ovf = 0;
    if (m_pend) begin
      if (old_valid && !rdy) m_ovf = 1;
      else begin
        dec = ref_decode(m_wf, m_wp);
        m_data = dec[15:0]; m_err = dec[16]; m_valid = 1;
      end
    end
    m_pend = 0;
    if (v && (s || m_aligned)) begin
      if (s) begin m_aligned = 1; m_k = 0; m_f = 0; m_p = 0; end
      m_f[m_k] = f;
      m_p[2*m_k +: 2] = {r, p};
      if (m_k == 6) begin m_pend = 1; m_wf = m_f; m_wp = m_p; m_k = 0; end
      else m_k++;
    end
  endtask

  task automatic compare_all();
    check_eq("data", RxData, m_data);
    check_eq("valid", RxDataValid, m_valid);
    check_eq("err", RxCodeErr, m_err);
    check_eq("ovf", RxOverflow, m_ovf);
    check_eq("aligned", RxAligned, m_aligned);
  endtask

  // One clock: drive inputs after a negedge, let the model follow the edge, compare.
  task automatic tick(input bit v, input bit f, input bit r, input bit p,
                      input bit s, input bit rdy);
    RxSymValid = v; RxSymFlip = f; RxSymRotation = r; RxSymPolarity = p;
    RxSync = s; RxDataReady = rdy;
    @(posedge Clk);
    if (!RstN) model_reset();
    else model_step(v, f, r, p, s, rdy);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    tick(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic send_word(input bit [6:0] f, input bit [13:0] pr, input bit sync, input bit rdy);
    for (int k = 0; k < 7; k++)
      tick(1, f[k], pr[2*k+1], pr[2*k], sync && (k == 0), rdy);
  endtask

  task automatic check_out(input string tag, input bit [15:0] d, input bit e, input bit v);
    check_eq({tag, "_data"}, RxData, d);
    check_eq({tag, "_err"}, RxCodeErr, e);
    check_eq({tag, "_valid"}, RxDataValid, v);
  endtask

  initial begin
    RstN = 0; RxSymValid = 0; RxSymFlip = 0; RxSymRotation = 0;
    RxSymPolarity = 0; RxSync = 0; RxDataReady = 1;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    compare_all();
    RstN = 1;
    idle(1);

    // Zero-flip word, then back-to-back words needing no further sync
    send_word(7'h00, 14'h1234, 1, 1); idle(1);
    check_out("zero_flip", 16'h1234, 0, 1);
    send_word(7'h08, spread(7'h08, 14'h0ABC), 0, 1); idle(1);
    check_out("one_flip", 16'h7ABC, 0, 1);
    send_word(7'h0A, spread(7'h0A, 14'h0155), 0, 1); idle(1);
    check_out("two_flip13", 16'hCD55, 0, 1);
    send_word(7'h03, spread(7'h03, 14'h0000), 0, 1); idle(1);
    check_out("two_flip01", 16'hB000, 0, 1);

    // Illegal codes
    send_word(7'h60, 14'h0000, 0, 1); idle(1);
    check_out("err_60", 16'h0000, 1, 1);
    send_word(7'h07, 14'h0000, 0, 1); idle(1);
    check_out("err_07", 16'h0000, 1, 1);
    send_word(7'h04, 14'h0010, 0, 1); idle(1);
    check_out("err_nz", 16'h0000, 1, 1);
    idle(1);

    // Overflow while stalled
    send_word(7'h00, 14'h0123, 0, 0);
    send_word(7'h00, 14'h0456, 0, 0);
    idle(0);
    check_eq("ovf_pulse", RxOverflow, 1'b1);
    check_out("ovf_hold", 16'h0123, 0, 1);
    idle(0);
    check_eq("ovf_single", RxOverflow, 1'b0);
    idle(1);
    check_eq("ovf_xfer_valid", RxDataValid, 1'b0);

    // Resync at the 5th symbol
    for (int k = 0; k < 4; k++) tick(1, 0, 1, 1, k == 0, 1);
    send_word(7'h00, 14'h2BCD, 1, 1); idle(1);
    check_out("resync", 16'h2BCD, 0, 1);

    // Asynchronous reset mid-word while an output is held
    for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 0, 0);
    #2 RstN = 0;
    #1;
    check_out("async_rst", 16'h0000, 0, 0);
    check_eq("async_rst_aligned", RxAligned, 1'b0);
    model_reset();
    tick(1, 0, 1, 1, 1, 1);
    RstN = 1;
    send_word(7'h00, 14'h1111, 0, 1); idle(1);
    check_out("post_rst_nosync", 16'h0000, 0, 0);
    check_eq("post_rst_aligned", RxAligned, 1'b0);
    send_word(7'h00, 14'h2222, 1, 1); idle(1);
    check_out("post_rst_sync", 16'h2222, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit v, f, r, p, s, rdy;
      v   = ($urandom_range(0, 9) < 8);
      s   = ($urandom_range(0, 39) == 0);
      f   = ($urandom_range(0, 6) == 0);
      r   = $urandom_range(0, 1);
      p   = $urandom_range(0, 1);
      if (f && $urandom_range(0, 9) != 0) begin r = 0; p = 0; end
      rdy = ($urandom_range(0, 9) < 7);
      tick(v, f, r, p, s, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cphy_demapper.md
CPHY_DEMAPPER -- requirements
Module: cphy_demapper

Interface
REQ-001 Parameter: CHECK_FLIPPED_ZERO, default 1, when 1 a flipped symbol with nonzero rotation or polarity is a code error.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 RstN  input  1  reset, asynchronous assert, active-low.
REQ-004 RxSymValid  input  1  one receive symbol present this cycle.
REQ-005 RxSymFlip  input  1  flip bit of the symbol.
REQ-006 RxSymRotation  input  1  rotation bit of the symbol.
REQ-007 RxSymPolarity  input  1  polarity bit of the symbol.
REQ-008 RxSync  input  1  qualified by RxSymValid; marks the symbol as S0 of a word.
REQ-009 RxDataReady  input  1  downstream accepts RxData.
REQ-010 RxData  output  16  decoded word.
REQ-011 RxDataValid  output  1  RxData valid, held until accepted.
REQ-012 RxCodeErr  output  1  word has an illegal symbol group; qualified by RxDataValid.
REQ-013 RxOverflow  output  1  one-cycle pulse: completed word dropped.
REQ-014 RxAligned  output  1  word alignment established.

Function
REQ-015 Symbols arrive serially S0 first, S6 last; a word is 7 symbols; no backpressure toward the symbol source.
REQ-016 Symbol k carries data pair P[k] = {rotation, polarity}; data bits map polarity to the even bit and rotation to the odd bit.
REQ-017 States: UNALIGNED (all symbols discarded) and COLLECT (3-bit symbol counter 0..6).
REQ-018 UNALIGNED -> COLLECT on RxSymValid=1 with RxSync=1; that symbol is stored as S0 and the counter becomes 1.
REQ-019 In COLLECT, RxSync=1 with RxSymValid=1 discards the partial word and stores the symbol as S0; RxSync with RxSymValid=0 is ignored.
REQ-020 After S6 is accepted, the counter wraps to 0; the next valid symbol is S0 without requiring RxSync.
REQ-021 RxAligned is 1 in COLLECT and 0 in UNALIGNED.
REQ-022 Zero flips: RxData = {2'b00, P[6], P[5], ..., P[0]}.
REQ-023 Exactly one flip at position p: RxData[15:12] = 4 + p; RxData[11:0] = the 6 unflipped pairs in ascending index order, lowest index in bits [1:0].
REQ-024 Exactly two flips at (i < j), excluding (5,6): n = lexicographic index of (i,j), with (0,1)=0 ... (4,6)=19; RxData[15:10] = 6'h2C + n; RxData[9:0] = the 5 unflipped pairs in ascending index order.
REQ-025 Flip pattern 7'h60, three or more flips, or (CHECK_FLIPPED_ZERO=1 and any flipped symbol with nonzero pair) -> RxCodeErr=1, RxData=16'h0000.
REQ-026 Latency: S6 accepted at edge t -> RxData, RxDataValid and RxCodeErr updated and visible after edge t+1 (registered).
REQ-027 Output handshake: a transfer occurs when RxDataValid=1 and RxDataReady=1; RxDataValid clears after a transfer unless a new word loads in the same cycle.
REQ-028 A word completing while RxDataValid=1 and RxDataReady=0 is dropped; held RxData/RxCodeErr are unchanged; RxOverflow pulses 1 at t+1.
REQ-029 A word completing while RxDataReady=1 replaces the output; RxDataValid stays 1 and no overflow is reported.
REQ-030 RxData and RxCodeErr are stable while RxDataValid=1 and RxDataReady=0.

Reset
REQ-031 While RstN=0: state UNALIGNED, counter 0, partial word cleared, RxData=16'h0000, RxDataValid=0, RxCodeErr=0, RxOverflow=0, RxAligned=0, all asynchronously.
REQ-032 Reset mid-word discards the partial word and any held output; after release, RxSync is required again.

Verification
REQ-033 RxSync on S0, 7 symbols with flips 0 carrying 0x1234 (pairs S0..S6 = 00,01,11,00,10,00,01) -> RxData=0x1234, RxDataValid=1, RxCodeErr=0 one cycle after S6.
REQ-034 Flip only on S3, unflipped pairs carrying 0xABC -> RxData=0x7ABC, RxCodeErr=0.
REQ-035 Flips on S1 and S3, unflipped pairs carrying 0x155 -> RxData=0xCD55; flips on S0 and S1 with 0x000 -> RxData=0xB000.
REQ-036 Flip patterns 7'h60, 7'h07, and flip on S2 with pair 01 (CHECK_FLIPPED_ZERO=1) -> RxCodeErr=1, RxData=0x0000, RxDataValid=1.
REQ-037 RxDataReady=0, two consecutive words -> first word held, RxOverflow single pulse after the second S6; then RxDataReady=1 -> first word transferred, RxDataValid=0 next cycle.
REQ-038 RxSync at the 5th symbol of a word -> partial word discarded and realigned; RstN pulsed low mid-word -> outputs 0 immediately, symbols ignored until RxSync.
